// File: rtl/rom_dl_if.sv
// ---------------------------------------------------------------------------
// rom_dl_if
// Bus bundle between the HPS ioctl download port and the core ROM write port.
//   dl_active : download in progress (ioctl_download)
//   dl_wr     : one-cycle byte strobe (ioctl_wr)
//   dl_addr   : 17-bit download byte address
//   dl_data   : download byte
//   rom_we    : one-hot per-region write enable
//   rom_addr  : region-local byte offset
//   rom_data  : write data
//   rom_ready : ROM port accepts a write this cycle
// master = download source / ROM sink side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface rom_dl_if;
   logic        dl_active;
   logic        dl_wr;
   logic [16:0] dl_addr;
   logic [7:0]  dl_data;
   logic [3:0]  rom_we;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_ready;

   modport master (
      output dl_active, dl_wr, dl_addr, dl_data, rom_ready,
      input  rom_we, rom_addr, rom_data
   );

   modport slave (
      input  dl_active, dl_wr, dl_addr, dl_data, rom_ready,
      output rom_we, rom_addr, rom_data
   );
endinterface

// File: rtl/rom_dl_sequencer.sv
// ---------------------------------------------------------------------------
// rom_dl_sequencer
// Routes ioctl download bytes into four ROM regions through a small FIFO,
// counts bytes per region and holds the core in reset until a complete,
// error-free image is loaded, plus a reset-stretch interval.
// Ports:
//   clk_sys      : system clock
//   reset        : synchronous active-high reset
//   bus          : rom_dl_if.slave (download input, ROM write output)
//   core_reset_n : active-low core reset, high only in RUN
//   dl_done      : valid image loaded, core running
//   dl_err       : sticky [0] FIFO overflow, [1] out-of-range address,
//                  [2] region byte-count mismatch
// ---------------------------------------------------------------------------
module rom_dl_sequencer #(
   parameter logic [16:0] R0_BASE  = 17'h00000,
   parameter logic [16:0] R0_LEN   = 17'h00800,
   parameter logic [16:0] R1_BASE  = 17'h00800,
   parameter logic [16:0] R1_LEN   = 17'h00800,
   parameter logic [16:0] R2_BASE  = 17'h01000,
   parameter logic [16:0] R2_LEN   = 17'h00200,
   parameter logic [16:0] R3_BASE  = 17'h01200,
   parameter logic [16:0] R3_LEN   = 17'h00100,
   parameter int          RST_HOLD = 16
) (
   input  logic       clk_sys,
   input  logic       reset,
   rom_dl_if.slave    bus,
   output logic       core_reset_n,
   output logic       dl_done,
   output logic [2:0] dl_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   localparam logic [3:0][16:0] BASE_ARR = {R3_BASE, R2_BASE, R1_BASE, R0_BASE};
   localparam logic [3:0][16:0] LEN_ARR  = {R3_LEN,  R2_LEN,  R1_LEN,  R0_LEN};

   logic [2:0]  state_reg, state_next;
   logic [7:0]  hold_cnt_reg;
   logic [2:0]  dl_err_reg;

   // output (write) register
   logic [3:0]  rom_we_reg;
   logic [10:0] rom_addr_reg;
   logic [7:0]  rom_data_reg;

   // FIFO storage and control
   logic [1:0]  fifo_region [4];
   logic [10:0] fifo_offset [4];
   logic [7:0]  fifo_data   [4];
   logic [1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [2:0]  count_reg;

   logic [3:0]        hit;
   logic [3:0][10:0]  off;
   logic [3:0]        count_ok;
   logic [1:0]        in_region;
   logic [10:0]       in_offset;
   logic              addr_ok;

   logic load_entry, push_req, push, pop, full, out_busy, complete;
   logic ovf, oor, mismatch, drain_done, counts_ok;

   // ---------------- address decode ----------------
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dec
         logic [17:0] lim;
         assign lim     = {1'b0, BASE_ARR[gi]} + {1'b0, LEN_ARR[gi]};
         assign hit[gi] = (bus.dl_addr >= BASE_ARR[gi]) && ({1'b0, bus.dl_addr} < lim);
         assign off[gi] = 11'(bus.dl_addr - BASE_ARR[gi]);
      end
   endgenerate

   always_comb begin
      in_region = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (hit[i]) in_region = 2'(i);
      end
   end

   assign addr_ok   = |hit;
   assign in_offset = off[in_region];

   // ---------------- FIFO / handshake ----------------
   // The output register is counted as one of the four slots, so the FIFO
   // holds four bytes in total while the ROM port is stalled.
   assign load_entry = bus.dl_active && (state_reg != S_LOAD);
   assign out_busy   = |rom_we_reg;
   assign complete   = out_busy && bus.rom_ready;
   assign full       = (count_reg + {2'b00, out_busy}) >= 3'd4;
   assign pop        = (count_reg != 3'd0) && (!out_busy || bus.rom_ready);
   assign push_req   = (state_reg == S_LOAD) && bus.dl_wr && bus.dl_active;
   assign push       = push_req && addr_ok && (!full || complete);
   assign ovf        = push_req && addr_ok && full && !complete;
   assign oor        = push_req && !addr_ok;

   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_region[wr_ptr_reg] <= in_region;
         fifo_offset[wr_ptr_reg] <= in_offset;
         fifo_data[wr_ptr_reg]   <= bus.dl_data;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset || load_entry) begin
         wr_ptr_reg <= 2'd0;
         rd_ptr_reg <= 2'd0;
         count_reg  <= 3'd0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
         count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
      end
   end

   // Output register: reloads from the FIFO head when empty or as the
   // current write completes; otherwise held stable through a stall.
   always_ff @(posedge clk_sys) begin
      if (reset || load_entry) begin
         rom_we_reg   <= 4'd0;
         rom_addr_reg <= 11'd0;
         rom_data_reg <= 8'd0;
      end else if (pop) begin
         rom_we_reg   <= 4'b0001 << fifo_region[rd_ptr_reg];
         rom_addr_reg <= fifo_offset[rd_ptr_reg];
         rom_data_reg <= fifo_data[rd_ptr_reg];
      end else if (complete) begin
         rom_we_reg   <= 4'd0;
      end
   end

   // ---------------- per-region byte counters ----------------
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
         logic [11:0] cnt_reg;
         always_ff @(posedge clk_sys) begin
            if (reset || load_entry) begin
               cnt_reg <= 12'd0;
            end else if (complete && rom_we_reg[gi] && (cnt_reg != 12'hFFF)) begin
               cnt_reg <= cnt_reg + 12'd1;
            end
         end
         assign count_ok[gi] = (cnt_reg == LEN_ARR[gi][11:0]);
      end
   endgenerate

   assign counts_ok = &count_ok;

   // ---------------- control FSM ----------------
   assign drain_done = (count_reg == 3'd0) && !out_busy;

   always_comb begin
      state_next = state_reg;
      mismatch   = 1'b0;
      case (state_reg)
         S_LOAD:  if (!bus.dl_active) state_next = S_DRAIN;
         S_DRAIN: begin
            // single-cycle image check once nothing is left in flight
            if (drain_done) begin
               if ((dl_err_reg == 3'd0) && counts_ok) begin
                  state_next = S_HOLD;
               end else begin
                  state_next = S_ERR;
                  mismatch   = !counts_ok;
               end
            end
         end
         S_HOLD:  if (hold_cnt_reg == 8'd0) state_next = S_RUN;
         default: ;
      endcase
      if (load_entry) begin
         state_next = S_LOAD;
         mismatch   = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hold_cnt_reg <= 8'd0;
      end else if ((state_reg == S_DRAIN) && (state_next == S_HOLD)) begin
         hold_cnt_reg <= 8'(RST_HOLD);
      end else if ((state_reg == S_HOLD) && (hold_cnt_reg != 8'd0)) begin
         hold_cnt_reg <= hold_cnt_reg - 8'd1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset || load_entry) begin
         dl_err_reg <= 3'd0;
      end else begin
         dl_err_reg <= dl_err_reg | {mismatch, oor, ovf};
      end
   end

   // ---------------- outputs ----------------
   assign bus.rom_we    = rom_we_reg;
   assign bus.rom_addr  = rom_addr_reg;
   assign bus.rom_data  = rom_data_reg;
   assign core_reset_n  = (state_reg == S_RUN);
   assign dl_done       = (state_reg == S_RUN);
   assign dl_err        = dl_err_reg;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rom_dl_sequencer
// Scoreboard bench: stimulus pushes the expected ROM write for every accepted
// byte; a negedge monitor pops and compares each completed write.
// ---------------------------------------------------------------------------
module tb_rom_dl_sequencer;
   localparam int RST_HOLD = 16;
   localparam int BASE_T [4] = '{'h0000, 'h0800, 'h1000, 'h1200};
   localparam int LEN_T  [4] = '{'h0800, 'h0800, 'h0200, 'h0100};

   typedef struct packed {
      logic [3:0]  we;
      logic [10:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       core_reset_n;
   logic       dl_done;
   logic [2:0] dl_err;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks   = 0;
   int  failures = 0;
   int  rise;

   rom_dl_if bus();

   rom_dl_sequencer dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .bus          (bus),
      .core_reset_n (core_reset_n),
      .dl_done      (dl_done),
      .dl_err       (dl_err)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic logic [7:0] dval(input int a);
      return 8'((a * 7) ^ (a >> 8) ^ 'h5A);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // expected write for an in-range address; out-of-range bytes expect nothing
   task automatic expect_byte(input int a);
      for (int r = 0; r < 4; r++) begin
         if (a >= BASE_T[r] && a < BASE_T[r] + LEN_T[r]) begin
            exp_q.push_back({4'(1 << r), 11'(a - BASE_T[r]), dval(a)});
         end
      end
   endtask

   task automatic send(input int a, input int gap);
      bus.dl_wr   = 1'b1;
      bus.dl_addr = 17'(a);
      bus.dl_data = dval(a);
      expect_byte(a);
      @(negedge clk_sys);
      if (gap > 1) begin
         bus.dl_wr = 1'b0;
         repeat (gap - 1) @(negedge clk_sys);
      end
   endtask

   task automatic download(input int n, input int gap, input bit bad);
      for (int a = 0; a < n; a++) begin
         if (bad && a == 'h400) send('h1300, gap);
         send(a, gap);
      end
      bus.dl_wr = 1'b0;
   endtask

   task automatic start_load();
      bus.dl_active = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_sys);
      chk(name, exp_q.size(), 0);
      repeat (4) @(negedge clk_sys);
   endtask

   // returns the index of the first negedge (counted from dl_active going low)
   // at which core_reset_n is high, or -1
   task automatic end_load_measure(output int r);
      bus.dl_active = 1'b0;
      r = -1;
      for (int k = 1; k <= RST_HOLD + 10; k++) begin
         @(negedge clk_sys);
         if (core_reset_n && r < 0) r = k;
      end
   endtask

   task automatic chk_stall();
      chk("stall_we",   bus.rom_we,   4'b0001);
      chk("stall_addr", bus.rom_addr, 11'h000);
      chk("stall_data", bus.rom_data, dval(0));
   endtask

   // monitor: a write completes at the next posedge when rom_we!=0 and rom_ready=1
   always @(negedge clk_sys) begin
      if (!reset && bus.rom_ready && bus.rom_we != 4'd0) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write actual we=%b addr=%h data=%h required none",
                     bus.rom_we, bus.rom_addr, bus.rom_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.rom_we, bus.rom_addr, bus.rom_data} !== mon_e) begin
               failures++;
               $display("FAIL rom_write actual we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                        bus.rom_we, bus.rom_addr, bus.rom_data, mon_e.we, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   initial begin
      reset         = 1'b1;
      bus.dl_active = 1'b0;
      bus.dl_wr     = 1'b0;
      bus.dl_addr   = 17'd0;
      bus.dl_data   = 8'd0;
      bus.rom_ready = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("rst_we",     bus.rom_we,   4'd0);
      chk("rst_addr",   bus.rom_addr, 11'd0);
      chk("rst_data",   bus.rom_data, 8'd0);
      chk("rst_core_n", core_reset_n, 1'b0);
      chk("rst_done",   dl_done,      1'b0);
      chk("rst_err",    dl_err,       3'd0);
      $display("txn reset: outputs checked");
      reset = 1'b0;
      @(negedge clk_sys);

      // full image, one byte every 4 cycles
      start_load();
      download('h1300, 4, 1'b0);
      wait_drain("t1_drain");
      end_load_measure(rise);
      // drop seen at edge 1, drain completes at edge 2, RUN RST_HOLD+1 edges later
      chk("t1_rise",     rise,   RST_HOLD + 3);
      chk("t1_done",     dl_done, 1'b1);
      chk("t1_err",      dl_err,  3'd0);
      $display("txn full_download_slow: rise=%0d done=%0d err=%b", rise, dl_done, dl_err);

      // RUN -> LOAD on dl_active
      start_load();
      chk("t5_core_n", core_reset_n, 1'b0);
      chk("t5_done",   dl_done,      1'b0);
      $display("txn reload_from_run: core_reset_n=%0d dl_done=%0d", core_reset_n, dl_done);

      // full image back-to-back with one out-of-range byte
      download('h1300, 1, 1'b1);
      wait_drain("t2_drain");
      bus.dl_active = 1'b0;
      repeat (RST_HOLD + 5) @(negedge clk_sys);
      chk("t2_err",    dl_err,       3'b010);
      chk("t2_core_n", core_reset_n, 1'b0);
      chk("t2_done",   dl_done,      1'b0);
      $display("txn bad_address: err=%b core_reset_n=%0d", dl_err, core_reset_n);

      // region 3 short by one byte
      start_load();
      chk("t4_err_clr1", dl_err, 3'd0);
      download('h12FF, 1, 1'b0);
      wait_drain("t4_drain1");
      bus.dl_active = 1'b0;
      repeat (RST_HOLD + 5) @(negedge clk_sys);
      chk("t4_err",    dl_err,       3'b100);
      chk("t4_core_n", core_reset_n, 1'b0);
      $display("txn short_region3: err=%b", dl_err);

      // complete image after the error
      start_load();
      chk("t4_err_clr2", dl_err, 3'd0);
      download('h1300, 1, 1'b0);
      wait_drain("t4_drain2");
      end_load_measure(rise);
      chk("t4_rise", rise,    RST_HOLD + 3);
      chk("t4_done", dl_done, 1'b1);
      chk("t4_err0", dl_err,  3'd0);
      $display("txn recovery_download: rise=%0d done=%0d", rise, dl_done);

      // overflow: ROM port stalled, dl_wr every cycle, 5th byte dropped
      start_load();
      bus.rom_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.dl_wr   = 1'b1;
         bus.dl_addr = 17'(i);
         bus.dl_data = dval(i);
         if (i < 4) expect_byte(i);
         @(negedge clk_sys);
         if (i >= 1) chk_stall();
      end
      bus.dl_wr = 1'b0;
      chk("t3_ovf", dl_err[0], 1'b1);
      repeat (4) begin
         @(negedge clk_sys);
         chk_stall();
      end
      bus.rom_ready = 1'b1;
      wait_drain("t3_drain");
      bus.dl_active = 1'b0;
      repeat (RST_HOLD + 5) @(negedge clk_sys);
      // overflow plus incomplete regions
      chk("t3_err",    dl_err,       3'b101);
      chk("t3_core_n", core_reset_n, 1'b0);
      $display("txn overflow_stall: err=%b", dl_err);

      // reset mid-LOAD with two bytes queued behind a stalled write
      start_load();
      bus.rom_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.dl_wr   = 1'b1;
         bus.dl_addr = 17'(i);
         bus.dl_data = dval(i);
         @(negedge clk_sys);
      end
      bus.dl_wr     = 1'b0;
      bus.dl_active = 1'b0;
      reset         = 1'b1;
      @(negedge clk_sys);
      chk("t6_we",     bus.rom_we,   4'd0);
      chk("t6_core_n", core_reset_n, 1'b0);
      chk("t6_done",   dl_done,      1'b0);
      chk("t6_err",    dl_err,       3'd0);
      reset         = 1'b0;
      bus.rom_ready = 1'b1;
      // any write appearing now would be a flushed FIFO entry
      repeat (8) @(negedge clk_sys);
      chk("t6_idle_core_n", core_reset_n, 1'b0);
      $display("txn reset_mid_load: we=%b core_reset_n=%0d", bus.rom_we, core_reset_n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
- Sits between the HPS ioctl download port and the core's ROM/PROM write ports in clk_sys.
- Decodes download addresses into four ROM regions and buffers bytes in a 4-entry FIFO, because the ROM port can stall through rom_ready.
- Counts the bytes written per region and holds the core in reset until a complete, error-free image has been written, plus a reset-stretch interval.
- Replaces ad-hoc wiring of ioctl_download into the core reset term.

Parameters:
- R0_BASE, 'h0000, region 0 start address (program ROM low)
- R0_LEN, 'h0800, region 0 length in bytes
- R1_BASE, 'h0800, region 1 start (program ROM high)
- R1_LEN, 'h0800, region 1 length
- R2_BASE, 'h1000, region 2 start (character ROM)
- R2_LEN, 'h0200, region 2 length
- R3_BASE, 'h1200, region 3 start (sync PROM)
- R3_LEN, 'h0100, region 3 length
- RST_HOLD, 16, cycles of core reset after a successful load (range 1..255)

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dl_active  in  1  download in progress (ioctl_download)
- dl_wr  in  1  one-cycle byte strobe (ioctl_wr)
- dl_addr  in  17  download byte address
- dl_data  in  8  download byte
- rom_we  out  4  one-hot per-region write enable
- rom_addr  out  11  region-local byte offset
- rom_data  out  8  write data
- rom_ready  in  1  ROM port accepts a write this cycle
- core_reset_n  out  1  active-low reset to the core
- dl_done  out  1  valid image loaded; core running
- dl_err  out  3  sticky: [0] FIFO overflow, [1] out-of-range address, [2] region byte-count mismatch

Behaviour:
- Reset values: rom_we=0, rom_addr=0, rom_data=0, core_reset_n=0, dl_done=0, dl_err=0. The FIFO is flushed, all counters are cleared and the state is IDLE.
- A reset asserted mid-download behaves the same way. A write already presented on rom_we is abandoned.
- States:
  - IDLE: core_reset_n=0, dl_done=0.
  - LOAD: core_reset_n=0.
  - DRAIN: core_reset_n=0.
  - HOLD: core_reset_n=0.
  - RUN: core_reset_n=1, dl_done=1.
  - ERR: core_reset_n=0, dl_err holds its non-zero value.
- Transitions:
  - From IDLE, RUN or ERR, dl_active=1 moves to LOAD on the next edge. Entering LOAD clears dl_err, dl_done, the region counters and the FIFO. core_reset_n is low in the first LOAD cycle.
  - LOAD moves to DRAIN when dl_active=0.
  - DRAIN moves to the check step when the FIFO is empty and no write is pending on the output.
  - Check, evaluated in a single cycle: if dl_err is zero and every region count equals its LEN, go to HOLD. Otherwise set the relevant dl_err bits and go to ERR.
  - HOLD loads a counter with RST_HOLD, decrements it each cycle, and moves to RUN in the cycle after the counter reaches 0.
  - dl_active=1 during DRAIN or HOLD returns the block to LOAD.
- Address decode:
  - A byte belongs to region i when BASE_i <= dl_addr < BASE_i+LEN_i.
  - rom_addr = dl_addr - BASE_i, truncated to 11 bits.
  - A byte matching no region is discarded and sets dl_err[1].
  - Regions must not overlap; behaviour with overlapping parameters is undefined.
- FIFO:
  - 4 entries of {region id, offset, data}.
  - A push happens when dl_wr=1 and dl_active=1 in LOAD. dl_wr outside LOAD is ignored.
  - A push while the FIFO is full and not popping in the same cycle drops the byte and sets dl_err[0].
  - A push and a pop in the same cycle on a full FIFO is accepted.
- Output and latency:
  - The output register loads from the FIFO head when it is empty, or when the current write completes.
  - A write completes on any edge where rom_we≠0 and rom_ready=1.
  - rom_we, rom_addr and rom_data stay stable until the write completes.
  - With rom_ready tied high, dl_wr sampled at edge n gives rom_we high in the cycle after edge n+1, a latency of 2 cycles.
  - Back-to-back writes sustain 1 byte per cycle.
- Counters: one counter per region, 12 bits wide, saturating at 4095. Each increments when a write to its region completes. Duplicate addresses count again, so an over-long image fails the check with dl_err[2].

Test Plan:
- Download of exactly 'h1300 bytes at addresses 0..'h12FF, one byte every 4 cycles, rom_ready=1:
  - rom_we sequence is 0001 ×'h800, 0010 ×'h800, 0100 ×'h200, 1000 ×'h100.
  - Byte at 'h1005 appears as rom_addr='h005.
  - core_reset_n rises RST_HOLD+1 cycles after the drain completes; dl_done=1, dl_err=0.
- Same download but dl_addr='h1300 inserted once: byte is discarded, no rom_we; the block ends in ERR with dl_err=3'b010 and core_reset_n=0.
- dl_wr on every cycle with rom_ready held low for 10 cycles: the first 4 bytes are buffered, the 5th is dropped and dl_err[0]=1; rom_we/rom_addr/rom_data are stable throughout the stall.
- Region 3 short by 1 byte ('hFF bytes) → dl_err=3'b100 and ERR state; a subsequent complete download clears dl_err and reaches RUN.
- While in RUN, raise dl_active → core_reset_n=0 and dl_done=0 in the first LOAD cycle.
- Assert reset for 1 cycle mid-LOAD with 2 FIFO entries pending → rom_we=0 the next cycle, FIFO empty, state IDLE, core_reset_n=0.
